// File: rtl/rst_sequencer.sv
// Staged per-domain reset release once PLL lock has been seen stable; any abort re-asserts all domains.
// All outputs registered; pll_lock_i crosses into wb_clk_i through a 2-flop synchroniser.
module rst_sequencer #(
  parameter int NUM_DOMAINS        = 4,
  parameter int STAGE_CYCLES       = 16,
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int MIN_ASSERT_CYCLES  = 8,
  parameter int CNT_W              = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   async_rst_i,
  input  logic                   pll_lock_i,
  input  logic                   soft_rst_req_i,
  input  logic                   dbg_rst_hold_i,
  output logic [NUM_DOMAINS-1:0] rst_o,
  output logic                   all_released_o,
  output logic [2:0]             state_o,
  output logic [7:0]             lock_loss_cnt_o
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    S_ASSERT    = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t           state;
  logic             lock_meta;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             lock_lost;
  logic             abort;

  always_ff @(posedge wb_clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock_i;
      lock_s    <= lock_meta;
    end
  end

  // Lock loss only counts once the sequencer has started releasing domains.
  assign lock_lost = ((state == S_RELEASE) || (state == S_RUN)) && !lock_s;
  assign abort     = (state != S_ASSERT) && (soft_rst_req_i || dbg_rst_hold_i || lock_lost);

  always_ff @(posedge wb_clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state           <= S_ASSERT;
      cnt             <= '0;
      idx             <= '0;
      rst_o           <= '1;
      all_released_o  <= 1'b0;
      lock_loss_cnt_o <= 8'd0;
    end else begin
      if (lock_lost && (lock_loss_cnt_o != 8'hFF)) begin
        lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
      end

      if (abort) begin
        state          <= S_ASSERT;
        cnt            <= '0;
        idx            <= '0;
        rst_o          <= '1;
        all_released_o <= 1'b0;
      end else begin
        case (state)
          S_ASSERT: begin
            rst_o <= '1;
            if (soft_rst_req_i) begin
              cnt <= '0;
            end else if ((cnt == ASSERT_LAST) && !dbg_rst_hold_i) begin
              state <= S_WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt != ASSERT_LAST) begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_WAIT_LOCK: begin
            rst_o <= '1;
            if (lock_s) begin
              state <= S_STABLE;
              cnt   <= '0;
            end
          end
          S_STABLE: begin
            if (!lock_s) begin
              state <= S_WAIT_LOCK;
            end else if (cnt == STABLE_LAST) begin
              state <= S_RELEASE;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_RELEASE: begin
            if (cnt == STAGE_LAST) begin
              rst_o[idx] <= 1'b0;
              cnt        <= '0;
              idx        <= idx + IDX_ONE;
              // The final domain's release and RUN entry land on the same edge.
              if (idx == IDX_LAST) begin
                state          <= S_RUN;
                all_released_o <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_RUN: begin
            rst_o          <= '0;
            all_released_o <= 1'b1;
          end
          default: begin
            state <= S_ASSERT;
            cnt   <= '0;
            idx   <= '0;
            rst_o <= '1;
          end
        endcase
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed scenarios plus random segments, every cycle checked
// against a phase/elapsed-time reference model.
module tb_rst_sequencer;

  localparam int N      = 4;
  localparam int STAGE  = 16;
  localparam int LSTAB  = 64;
  localparam int MINA   = 8;

  logic         wb_clk = 1'b0;
  logic         async_rst;
  logic         pll_lock;
  logic         soft_req;
  logic         dbg_hold;
  logic [N-1:0] rst_vec;
  logic         all_rel;
  logic [2:0]   state;
  logic [7:0]   loss_cnt;
  logic [15:0]  dut_vec;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: phase (0..4), cycles elapsed in phase, loss count, lock pipeline
  int m_phase;
  int m_t;
  int m_loss;
  bit m_ls;
  bit lock_q[$];

  rst_sequencer #(
    .NUM_DOMAINS(N), .STAGE_CYCLES(STAGE), .LOCK_STABLE_CYCLES(LSTAB),
    .MIN_ASSERT_CYCLES(MINA), .CNT_W(8)
  ) dut (
    .wb_clk_i       (wb_clk),
    .async_rst_i    (async_rst),
    .pll_lock_i     (pll_lock),
    .soft_rst_req_i (soft_req),
    .dbg_rst_hold_i (dbg_hold),
    .rst_o          (rst_vec),
    .all_released_o (all_rel),
    .state_o        (state),
    .lock_loss_cnt_o(loss_cnt)
  );

  always #5 wb_clk = ~wb_clk;

  assign dut_vec = {state, all_rel, loss_cnt, rst_vec};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_t     = 0;
    m_loss  = 0;
    m_ls    = 1'b0;
    lock_q.delete();
    lock_q.push_back(1'b0);
  endtask

  task automatic model_step();
    bit lost;
    bit abrt;
    lost = (m_phase >= 3) && !m_ls;
    abrt = (m_phase != 0) && (soft_req || dbg_hold || lost);
    if (lost && m_loss < 255) m_loss++;
    if (abrt) begin
      m_phase = 0;
      m_t     = 0;
    end else begin
      case (m_phase)
        0: begin
          if (soft_req) m_t = 0;
          else if (m_t >= MINA - 1 && !dbg_hold) begin m_phase = 1; m_t = 0; end
          else m_t++;
        end
        1: if (m_ls) begin m_phase = 2; m_t = 0; end
        2: begin
          if (!m_ls) m_phase = 1;
          else if (m_t == LSTAB - 1) begin m_phase = 3; m_t = 0; end
          else m_t++;
        end
        3: begin
          m_t++;
          if (m_t == N * STAGE) m_phase = 4;
        end
        default: ;
      endcase
    end
    lock_q.push_back(pll_lock);
    m_ls = lock_q.pop_front();
  endtask

  function automatic logic [15:0] model_out();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++)
      r[k] = !((m_phase == 4) || (m_phase == 3 && m_t >= (k + 1) * STAGE));
    return {3'(m_phase), (m_phase == 4), 8'(m_loss), r};
  endfunction

  task automatic tick();
    @(posedge wb_clk);
    if (async_rst) model_reset();
    else model_step();
    @(negedge wb_clk);
    check_val("cycle", {16'd0, dut_vec}, {16'd0, model_out()});
  endtask

  task automatic wait_state(input int s, input int budget);
    int n;
    n = 0;
    while (state != 3'(s) && n < budget) begin
      tick();
      n++;
    end
    check_val("wait_state", {29'd0, state}, s);
  endtask

  task automatic do_reset();
    @(negedge wb_clk);
    async_rst = 1'b1;
    soft_req  = 1'b0;
    dbg_hold  = 1'b0;
    #1;
    model_reset();
    check_val("reset_vals", {16'd0, dut_vec}, {16'd0, 3'd0, 1'b0, 8'd0, 4'hF});
    repeat (3) tick();
    async_rst = 1'b0;
  endtask

  initial begin
    int n;
    int r;
    async_rst = 1'b1;
    pll_lock  = 1'b1;
    soft_req  = 1'b0;
    dbg_hold  = 1'b0;
    model_reset();

    // 1: full sequence with constant lock
    do_reset();
    repeat (136) tick();
    check_val("pre_run_rst", {28'd0, rst_vec}, 32'h8);
    check_val("pre_run_all", {31'd0, all_rel}, 0);
    tick();
    check_val("run_rst", {28'd0, rst_vec}, 32'h0);
    check_val("run_all", {31'd0, all_rel}, 1);

    // 2: lock drop in RUN aborts three edges later
    pll_lock = 1'b0;
    tick();
    tick();
    check_val("run_hold", {29'd0, state}, 4);
    tick();
    check_val("loss_rst", {28'd0, rst_vec}, 32'hF);
    check_val("loss_state", {29'd0, state}, 0);
    check_val("loss_cnt1", {24'd0, loss_cnt}, 1);
    pll_lock = 1'b1;
    wait_state(4, 400);

    // 3: one-cycle lock glitch mid-STABLE restarts the stability window
    do_reset();
    wait_state(2, 100);
    repeat (40) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_state(1, 10);
    wait_state(2, 10);
    n = 0;
    while (state != 3'd3 && n < 200) begin tick(); n++; end
    check_val("stable_len", n, LSTAB);
    check_val("glitch_loss", {24'd0, loss_cnt}, 0);

    // 4: soft request on domain-1 terminal cycle, then soft during ASSERT hold
    repeat (31) tick();
    check_val("dom0_only", {28'd0, rst_vec}, 32'hE);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    check_val("soft_abort", {28'd0, rst_vec}, 32'hF);
    repeat (6) tick();
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    n = 0;
    while (state != 3'd1 && n < 50) begin tick(); n++; end
    check_val("assert_restart", n, MINA);

    // 5: debug hold from RUN
    wait_state(4, 400);
    dbg_hold = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check_val("dbg_rst", {28'd0, rst_vec}, 32'hF);
    end
    dbg_hold = 1'b0;
    tick();
    check_val("dbg_exit", {29'd0, state}, 1);
    wait_state(4, 400);

    // random segments
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 3))
        0: begin
          pll_lock = 1'b1;
          repeat ($urandom_range(80, 200)) tick();
        end
        1: begin
          repeat ($urandom_range(20, 80)) begin
            pll_lock = ($urandom % 16) != 0;
            soft_req = ($urandom % 32) == 0;
            dbg_hold = ($urandom % 24) == 0;
            tick();
          end
          soft_req = 1'b0;
          dbg_hold = 1'b0;
        end
        2: begin
          dbg_hold = 1'b1;
          repeat ($urandom_range(5, 30)) tick();
          dbg_hold = 1'b0;
        end
        default: begin
          pll_lock = 1'b0;
          repeat ($urandom_range(1, 10)) tick();
          pll_lock = 1'b1;
        end
      endcase
    end

    // 6: saturate the lock-loss counter
    pll_lock = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wait_state(3, 300);
      r = $urandom_range(0, 100);
      repeat (r) tick();
      pll_lock = 1'b0;
      tick();
      tick();
      soft_req = $urandom_range(0, 1);
      tick();
      soft_req = 1'b0;
      pll_lock = 1'b1;
    end
    check_val("loss_sat", {24'd0, loss_cnt}, 255);

    // async reset mid-RELEASE takes effect without a clock edge
    wait_state(3, 300);
    repeat (20) tick();
    #2 async_rst = 1'b1;
    #1;
    check_val("async_imm", {16'd0, dut_vec}, {16'd0, 3'd0, 1'b0, 8'd0, 4'hF});
    model_reset();
    tick();
    async_rst = 1'b0;
    wait_state(4, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
